csr_file: RTL and testbench
===========================

# csr_file

Machine-mode control and status register unit for the single-cycle RV32I core. It sits beside the integer register file in the execute/writeback path: it consumes the register file's first read port (`rdata1`) as CSR source data. It returns the old CSR value to the writeback mux, which feeds the register file's `wdata`. It also owns timer-interrupt entry and `mret`, producing the PC redirect.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  an instruction is executing this cycle
- csr_en  in  1  current instruction is a Zicsr instruction
- csr_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr  in  12  CSR address (instr[31:20])
- rs1_idx  in  5  rs1 field; zero-extended uimm for the immediate variants
- rs1_data  in  32  register file `rdata1`
- is_mret  in  1  current instruction is `mret`
- pc  in  32  PC of the current instruction
- timer_irq  in  1  level timer interrupt request
- csr_rdata  out  32  old CSR value, to the writeback mux
- epc_taken  out  1  redirect fetch this cycle
- epc  out  32  redirect target

## Operation
- Implemented CSRs and their writable bits:
  - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] hardwired 2'b11; all other bits 0.
  - mie 0x304: MTIE[7].
  - mtvec 0x305: BASE[31:2], MODE[0]; bit 1 reads 0.
  - mepc 0x341: [31:2]; bits [1:0] read 0.
  - mcause 0x342: all 32 bits.
  - mip 0x344: MTIP[7], read-only; writes ignored.
  - mcycle 0xB00 / mcycleh 0xB80: 64-bit cycle counter, fully writable.
- Unimplemented addresses read 0; writes to them are ignored. No illegal-instruction trap is raised.
- Source operand: `rs1_data` for funct3[2]=0; `{27'b0, rs1_idx}` for funct3[2]=1.
- New value by op:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - The result is then masked to the writable bits.
- Write enable = `instr_valid & csr_en & ~irq_take`, further qualified:
  - RS/RC/RSI/RCI do not write when `rs1_idx`==0.
  - RW/RWI always write.
- `csr_rdata` = current (pre-write) value of `csr_addr`, regardless of write enable.
- MTIP register is loaded with `timer_irq` every cycle; no other synchronisation.
- `irq_take` = `instr_valid & mstatus.MIE & mie.MTIE & mip.MTIP`. When taken:
  - mepc←pc, mcause←32'h8000_0007, MPIE←MIE, MIE←0.
  - The current instruction is squashed: CSR write suppressed, `is_mret` ignored.
  - `epc_taken`=1.
  - `epc` = mtvec.BASE<<2 if MODE=0, else (BASE<<2)+28.
- `mret` (`instr_valid & is_mret & ~irq_take`): MIE←MPIE, MPIE←1, `epc_taken`=1, `epc`={mepc[31:2],2'b00}.
- Priority: irq_take > mret > CSR write. `csr_en` and `is_mret` together: mret wins, no CSR write.
- mcycle:
  - Increments by 1 every cycle out of reset, carrying into mcycleh.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A CSR write to one half replaces that half's next value (no increment applied to it that cycle). The other half still receives its normal increment/carry.

## Timing
- Reset (async assert, synchronous-release sample at first edge after deassert):
  - mstatus=32'h0000_1800, mie=0, mip=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mcycle=0.
  - `epc_taken` forced 0 while rst=1; `epc`=0 while rst=1.
  - `csr_rdata` reflects reset CSR values.
- `csr_rdata`, `epc_taken`, `epc` are combinational from current state and inputs: zero-cycle latency.
- All CSR updates become visible on the following rising edge. A read-after-write to the same CSR in the next cycle returns the new value.
- `timer_irq` takes effect one cycle after assertion, via the MTIP register.
- Writing MIE=1 while MTIP=1 and MTIE=1: the trap is taken on the next valid instruction, not the writing one.
- `instr_valid`=0: no trap, no mret, no write, `epc_taken`=0. mcycle and MTIP still update.
- Reset mid-operation discards any in-flight write. Mid-cycle `epc_taken` drops to 0 immediately.

## Test plan
- Reset, MTVEC_RESET=32'h100: read 0x300 -> 32'h1800; 0x305 -> 32'h100; 0x344 -> 0; epc_taken=0.
- Write mie: CSRRW 0x304 with rs1_data=32'hFFFF_FFFF -> csr_rdata=0 that cycle; next read -> 32'h80. CSRRS x0 on 0x304 -> no write, value unchanged.
- Clear mstatus: CSRRCI 0x300 uimm=8 with mstatus=32'h1888 -> next read 32'h1880.
- Timer trap:
  - Setup: mtvec=32'h201 (vectored), MIE=1, MTIE=1, timer_irq=1.
  - Next valid instr at pc=32'h40 carries CSRRW 0x341 -> epc_taken=1, epc=32'h21C.
  - After the edge: mepc=32'h40 (CSR write suppressed), mcause=32'h8000_0007, mstatus=32'h1880.
- mret from that state -> epc=32'h40, epc_taken=1; next mstatus=32'h1888.
- Cycle counter: CSRRW mcycle=32'hFFFF_FFFF, mcycleh=32'hFFFF_FFFF -> two cycles after the last write, {mcycleh,mcycle} has wrapped to a small value (0 or 1), with no X.

Source files
------------

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - instruction-side bus between the core and the CSR unit
//
// Purpose: bundles the per-instruction CSR/trap controls driven by the core and
// the read data / PC redirect returned by the CSR unit.
// Signals:
//   instr_valid  core -> csr  an instruction is executing this cycle
//   csr_en       core -> csr  instruction is a Zicsr instruction
//   csr_funct3   core -> csr  Zicsr op (RW/RS/RC and immediate forms)
//   csr_addr     core -> csr  CSR address
//   rs1_idx      core -> csr  rs1 field / zero-extended uimm
//   rs1_data     core -> csr  register file rdata1
//   is_mret      core -> csr  instruction is mret
//   pc           core -> csr  PC of the current instruction
//   timer_irq    core -> csr  level timer interrupt request
//   csr_rdata    csr -> core  old CSR value for writeback
//   epc_taken    csr -> core  redirect fetch this cycle
//   epc          csr -> core  redirect target
interface csr_file_if;
  logic        instr_valid;
  logic        csr_en;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic        is_mret;
  logic [31:0] pc;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc;

  modport master (
    output instr_valid, csr_en, csr_funct3, csr_addr, rs1_idx, rs1_data,
           is_mret, pc, timer_irq,
    input  csr_rdata, epc_taken, epc
  );

  modport slave (
    input  instr_valid, csr_en, csr_funct3, csr_addr, rs1_idx, rs1_data,
           is_mret, pc, timer_irq,
    output csr_rdata, epc_taken, epc
  );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR unit with timer trap entry and mret
//
// Purpose: holds mstatus/mie/mtvec/mepc/mcause/mip/mcycle for a single-cycle
// RV32I core, executes Zicsr read-modify-writes, takes the machine timer
// interrupt and performs mret, producing the fetch redirect.
// Ports:
//   clk  in  core clock, all state updates on rising edge
//   rst  in  asynchronous active-high reset
//   bus  csr_file_if.slave  instruction controls in, csr_rdata/epc_taken/epc out
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  csr_file_if.slave  bus
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  logic        r_mie;
  logic        r_mpie;
  logic        r_mtie;
  logic        r_mtip;
  logic [31:0] r_mtvec;   // bit 1 always held at 0
  logic [31:0] r_mepc;    // bits [1:0] always held at 0
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;

  logic [31:0] w_mstatus;
  logic [31:0] w_old;
  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_op_ok;
  logic        w_irq_take;
  logic        w_mret;
  logic        w_wen;
  logic [31:0] w_trap_vec;
  logic [63:0] w_cyc_inc;
  logic [63:0] w_cyc_next;

  // MPP is hardwired to machine mode.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};

  always_comb begin
    w_old = 32'h0;
    case (bus.csr_addr)
      A_MSTATUS: w_old = w_mstatus;
      A_MIE:     w_old = {24'b0, r_mtie, 7'b0};
      A_MTVEC:   w_old = r_mtvec;
      A_MEPC:    w_old = r_mepc;
      A_MCAUSE:  w_old = r_mcause;
      A_MIP:     w_old = {24'b0, r_mtip, 7'b0};
      A_MCYCLE:  w_old = r_mcycle[31:0];
      A_MCYCLEH: w_old = r_mcycle[63:32];
      default:   w_old = 32'h0;
    endcase
  end

  assign w_src = bus.csr_funct3[2] ? {27'b0, bus.rs1_idx} : bus.rs1_data;

  always_comb begin
    w_new = w_old;
    case (bus.csr_funct3[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = w_old | w_src;
      2'b11:   w_new = w_old & ~w_src;
      default: w_new = w_old;
    endcase
  end

  // Set/clear forms with x0/uimm=0 are pure reads; funct3 x00 is not a CSR op.
  assign w_op_ok = (bus.csr_funct3[1:0] == 2'b01) ||
                   ((bus.csr_funct3[1:0] != 2'b00) && (bus.rs1_idx != 5'd0));

  assign w_irq_take = bus.instr_valid & r_mie & r_mtie & r_mtip;
  assign w_mret     = bus.instr_valid & bus.is_mret & ~w_irq_take;
  // mret beats a simultaneous CSR write.
  assign w_wen      = bus.instr_valid & bus.csr_en & ~w_irq_take & ~bus.is_mret & w_op_ok;

  // Vectored mode jumps to the timer-interrupt slot (cause 7 -> +28).
  assign w_trap_vec = r_mtvec[0] ? ((r_mtvec & 32'hFFFF_FFFC) + 32'd28)
                                 : (r_mtvec & 32'hFFFF_FFFC);

  assign bus.csr_rdata = w_old;
  assign bus.epc_taken = ~rst & (w_irq_take | w_mret);
  assign bus.epc       = rst        ? 32'h0 :
                         w_irq_take ? w_trap_vec :
                         w_mret     ? r_mepc : 32'h0;

  // A write to one half overrides only that half; the other keeps counting.
  assign w_cyc_inc  = r_mcycle + 64'd1;
  assign w_cyc_next = {(w_wen && bus.csr_addr == A_MCYCLEH) ? w_new : w_cyc_inc[63:32],
                       (w_wen && bus.csr_addr == A_MCYCLE)  ? w_new : w_cyc_inc[31:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtie   <= 1'b0;
      r_mtip   <= 1'b0;
      r_mtvec  <= MTVEC_RESET & 32'hFFFF_FFFD;
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
      r_mcycle <= 64'h0;
    end else begin
      r_mtip   <= bus.timer_irq;
      r_mcycle <= w_cyc_next;
      if (w_irq_take) begin
        r_mepc   <= bus.pc & 32'hFFFF_FFFC;
        r_mcause <= 32'h8000_0007;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_wen) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          A_MIE:    r_mtie   <= w_new[7];
          A_MTVEC:  r_mtvec  <= w_new & 32'hFFFF_FFFD;
          A_MEPC:   r_mepc   <= w_new & 32'hFFFF_FFFC;
          A_MCAUSE: r_mcause <= w_new;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   tot_cnt;

  csr_file_if bus ();

  csr_file #(.MTVEC_RESET(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic en, input logic [2:0] f3,
                       input logic [11:0] addr, input logic [4:0] idx,
                       input logic [31:0] data, input logic mret, input logic [31:0] pc);
    bus.instr_valid = valid;
    bus.csr_en      = en;
    bus.csr_funct3  = f3;
    bus.csr_addr    = addr;
    bus.rs1_idx     = idx;
    bus.rs1_data    = data;
    bus.is_mret     = mret;
    bus.pc          = pc;
    #1;
  endtask

  task automatic peek(input logic [11:0] addr);
    drive(1'b0, 1'b0, 3'b000, addr, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.timer_irq = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 1'b1, 32'h0);
    tot_cnt++;
    if (bus.epc_taken !== 1'b0) $display("FAIL rst_epc_taken got=%0h exp=0", bus.epc_taken);
    else pass_cnt++;
    tot_cnt++;
    if (bus.epc !== 32'h0) $display("FAIL rst_epc got=%08h exp=00000000", bus.epc);
    else pass_cnt++;
    step();
    step();
    rst = 1'b0;
    peek(12'h300);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1800) $display("FAIL rst_mstatus got=%08h exp=00001800", bus.csr_rdata);
    else pass_cnt++;
    peek(12'h305);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h100) $display("FAIL rst_mtvec got=%08h exp=00000100", bus.csr_rdata);
    else pass_cnt++;
    peek(12'h344);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL rst_mip got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    peek(12'h342);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL rst_mcause got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    step();
  endtask

  task automatic test_write_mie();
    drive(1'b1, 1'b1, 3'b001, 12'h304, 5'd5, 32'hFFFF_FFFF, 1'b0, 32'h0);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL mie_old got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    step();
    peek(12'h304);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h80) $display("FAIL mie_new got=%08h exp=00000080", bus.csr_rdata);
    else pass_cnt++;
    drive(1'b1, 1'b1, 3'b010, 12'h304, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 3'b011, 12'h304, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    peek(12'h304);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h80) $display("FAIL mie_x0_nowrite got=%08h exp=00000080", bus.csr_rdata);
    else pass_cnt++;
    drive(1'b1, 1'b1, 3'b001, 12'h344, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    peek(12'h344);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL mip_ro got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    drive(1'b1, 1'b1, 3'b001, 12'h123, 5'd1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step();
    peek(12'h123);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL unimpl_read got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
  endtask

  task automatic test_clear_mstatus();
    bus.timer_irq = 1'b0;
    drive(1'b1, 1'b1, 3'b001, 12'h300, 5'd2, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    peek(12'h300);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1888) $display("FAIL mstatus_mask got=%08h exp=00001888", bus.csr_rdata);
    else pass_cnt++;
    drive(1'b1, 1'b1, 3'b111, 12'h300, 5'd8, 32'h0, 1'b0, 32'h0);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1888) $display("FAIL rci_old got=%08h exp=00001888", bus.csr_rdata);
    else pass_cnt++;
    step();
    peek(12'h300);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1880) $display("FAIL rci_new got=%08h exp=00001880", bus.csr_rdata);
    else pass_cnt++;
  endtask

  task automatic test_timer_trap();
    drive(1'b1, 1'b1, 3'b001, 12'h305, 5'd3, 32'h0000_0203, 1'b0, 32'h0);
    step();
    peek(12'h305);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h201) $display("FAIL mtvec_mask got=%08h exp=00000201", bus.csr_rdata);
    else pass_cnt++;
    bus.timer_irq = 1'b1;
    step();
    peek(12'h344);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h80) $display("FAIL mip_mtip got=%08h exp=00000080", bus.csr_rdata);
    else pass_cnt++;
    // Enabling MIE while pending must not trap the enabling instruction.
    drive(1'b1, 1'b1, 3'b110, 12'h300, 5'd8, 32'h0, 1'b0, 32'h0000_0030);
    tot_cnt++;
    if (bus.epc_taken !== 1'b0) $display("FAIL mie_set_notrap got=%0h exp=0", bus.epc_taken);
    else pass_cnt++;
    step();
    drive(1'b1, 1'b1, 3'b001, 12'h341, 5'd4, 32'h0000_1234, 1'b0, 32'h0000_0040);
    tot_cnt++;
    if (bus.epc_taken !== 1'b1) $display("FAIL trap_taken got=%0h exp=1", bus.epc_taken);
    else pass_cnt++;
    tot_cnt++;
    if (bus.epc !== 32'h21C) $display("FAIL trap_epc got=%08h exp=0000021c", bus.epc);
    else pass_cnt++;
    step();
    peek(12'h341);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h40) $display("FAIL trap_mepc got=%08h exp=00000040", bus.csr_rdata);
    else pass_cnt++;
    peek(12'h342);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h8000_0007) $display("FAIL trap_mcause got=%08h exp=80000007", bus.csr_rdata);
    else pass_cnt++;
    peek(12'h300);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1880) $display("FAIL trap_mstatus got=%08h exp=00001880", bus.csr_rdata);
    else pass_cnt++;
  endtask

  task automatic test_mret();
    bus.timer_irq = 1'b0;
    // mret together with a CSRRW: mret wins and mepc is not overwritten.
    drive(1'b1, 1'b1, 3'b001, 12'h341, 5'd6, 32'h0000_0999, 1'b1, 32'h0000_0080);
    tot_cnt++;
    if (bus.epc_taken !== 1'b1) $display("FAIL mret_taken got=%0h exp=1", bus.epc_taken);
    else pass_cnt++;
    tot_cnt++;
    if (bus.epc !== 32'h40) $display("FAIL mret_epc got=%08h exp=00000040", bus.epc);
    else pass_cnt++;
    step();
    drive(1'b1, 1'b0, 3'b000, 12'h300, 5'd0, 32'h0, 1'b0, 32'h0000_0084);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1888) $display("FAIL mret_mstatus got=%08h exp=00001888", bus.csr_rdata);
    else pass_cnt++;
    tot_cnt++;
    if (bus.epc_taken !== 1'b0) $display("FAIL post_mret_notrap got=%0h exp=0", bus.epc_taken);
    else pass_cnt++;
    peek(12'h341);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h40) $display("FAIL mret_nowrite got=%08h exp=00000040", bus.csr_rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 3'b001, 12'hB80, 5'd7, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 3'b001, 12'hB00, 5'd7, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    peek(12'hB00);
    tot_cnt++;
    if (bus.csr_rdata !== 32'hFFFF_FFFF) $display("FAIL mcycle_wr got=%08h exp=ffffffff", bus.csr_rdata);
    else pass_cnt++;
    peek(12'hB80);
    tot_cnt++;
    if (bus.csr_rdata !== 32'hFFFF_FFFF) $display("FAIL mcycleh_wr got=%08h exp=ffffffff", bus.csr_rdata);
    else pass_cnt++;
    step();
    peek(12'hB00);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL mcycle_wrap got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    peek(12'hB80);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL mcycleh_wrap got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    step();
    peek(12'hB00);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1) $display("FAIL mcycle_inc got=%08h exp=00000001", bus.csr_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 1'b1, 32'h0);
    tot_cnt++;
    if (bus.epc_taken !== 1'b1) $display("FAIL pre_rst_taken got=%0h exp=1", bus.epc_taken);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    tot_cnt++;
    if (bus.epc_taken !== 1'b0) $display("FAIL mid_rst_taken got=%0h exp=0", bus.epc_taken);
    else pass_cnt++;
    peek(12'h342);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h0) $display("FAIL mid_rst_mcause got=%08h exp=00000000", bus.csr_rdata);
    else pass_cnt++;
    step();
    rst = 1'b0;
    peek(12'h300);
    tot_cnt++;
    if (bus.csr_rdata !== 32'h1800) $display("FAIL mid_rst_mstatus got=%08h exp=00001800", bus.csr_rdata);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    test_reset();
    test_write_mie();
    test_clear_mstatus();
    test_timer_trap();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
